// File: rtl/bnn_argmax_seq.sv
// bnn_argmax_seq: sequential argmax over captured BNN class scores, one compare per cycle.
module bnn_argmax_seq #(
  parameter int OSIZE_FEAT = 2,
  parameter int N_BITCONV  = 2,
  parameter int CLASS_W    = (OSIZE_FEAT > 1) ? $clog2(OSIZE_FEAT) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [OSIZE_FEAT-1:0][N_BITCONV-1:0] scores_i,
  input  logic                                 in_valid_i,
  output logic                                 in_ready_o,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic [CLASS_W-1:0]                   class_o,
  output logic [N_BITCONV-1:0]                 max_score_o,
  output logic                                 tie_o
);
  localparam int IDX_W = (OSIZE_FEAT > 1) ? $clog2(OSIZE_FEAT) : 1;
  localparam int CNT_W = $clog2(OSIZE_FEAT) + 1;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t                               state_q, state_d;
  logic [OSIZE_FEAT-1:0][N_BITCONV-1:0] sc_q, sc_d;
  logic [N_BITCONV-1:0]                 best_q, best_d, cur;
  logic [CLASS_W-1:0]                   idx_q, idx_d;
  logic [CNT_W-1:0]                     cnt_q, cnt_d;
  logic                                 tie_q, tie_d, rdy_q, last;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sc_q    <= '0;
      best_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      tie_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      best_q  <= best_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tie_q   <= tie_d;
      rdy_q   <= (state_d == IDLE);
    end
  end
  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    best_d  = best_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tie_d   = tie_q;
    cur     = sc_q[cnt_q[IDX_W-1:0]];
    last    = (cnt_q == CNT_W'(OSIZE_FEAT - 1));
    unique case (state_q)
      IDLE: if (rdy_q && in_valid_i) begin
        sc_d    = scores_i;
        best_d  = scores_i[0];
        idx_d   = '0;
        tie_d   = 1'b0;
        cnt_d   = CNT_W'(1);
        state_d = (OSIZE_FEAT == 1) ? DONE : SCAN;
      end
      SCAN: begin
        // strict > keeps the lowest index on equal scores
        if (cur > best_q) begin
          best_d = cur;
          idx_d  = CLASS_W'(cnt_q);
          tie_d  = 1'b0;
        end else if (cur == best_q) begin
          tie_d  = 1'b1;
        end
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = last ? DONE : SCAN;
      end
      DONE: state_d = out_ready_i ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // ready is a flop so it stays low through reset and rises one edge after release
  assign in_ready_o  = rdy_q;
  assign out_valid_o = (state_q == DONE);
  assign class_o     = idx_q;
  assign max_score_o = best_q;
  assign tie_o       = tie_q;
endmodule

// File: tb/tb_bnn_argmax_seq.sv
// tb_bnn_argmax_seq: directed table vectors plus back-pressure and mid-scan reset sequences.
module tb_bnn_argmax_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] scores = '0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, tie;
  logic [1:0]  cls;
  logic [3:0]  mx;
  int checks = 0, errors = 0;

  bnn_argmax_seq #(.OSIZE_FEAT(4), .N_BITCONV(4), .CLASS_W(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .scores_i(scores), .in_valid_i(in_valid),
    .in_ready_o(in_ready), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .class_o(cls), .max_score_o(mx), .tie_o(tie)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] sc;
    logic [1:0]  cls;
    logic [3:0]  mx;
    logic        tie;
  } vec_t;

  function automatic logic [15:0] mk(input int a0, a1, a2, a3);
    return {4'(a3), 4'(a2), 4'(a1), 4'(a0)};
  endfunction

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic accept(input logic [15:0] v);
    chk("ready_before_accept", int'(in_ready), 1);
    scores = v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scores = 16'($urandom);
    chk("busy_after_accept", int'(in_ready), 0);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    chk("latency", lat, 3);
  endtask

  task automatic check_res(input string n, input vec_t v);
    chk({n, "_class"}, int'(cls), int'(v.cls));
    chk({n, "_max"}, int'(mx), int'(v.mx));
    chk({n, "_tie"}, int'(tie), int'(v.tie));
  endtask

  task automatic release_out;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_ready", int'(in_ready), 1);
    chk("release_valid", int'(out_valid), 0);
  endtask

  vec_t vecs[7];
  int   lat;

  initial begin
    vecs[0] = '{mk(3, 9, 2, 9),    2'd1, 4'd9,  1'b1};
    vecs[1] = '{mk(0, 1, 2, 15),   2'd3, 4'd15, 1'b0};
    vecs[2] = '{mk(5, 5, 5, 5),    2'd0, 4'd5,  1'b1};
    vecs[3] = '{mk(7, 7, 8, 1),    2'd2, 4'd8,  1'b0};
    vecs[4] = '{mk(4, 2, 1, 0),    2'd0, 4'd4,  1'b0};
    vecs[5] = '{mk(0, 0, 0, 0),    2'd0, 4'd0,  1'b1};
    vecs[6] = '{mk(1, 15, 15, 3),  2'd1, 4'd15, 1'b1};

    #3;
    chk("rst_ready", int'(in_ready), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_class", int'(cls), 0);
    chk("rst_max", int'(mx), 0);
    chk("rst_tie", int'(tie), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("ready_before_edge", int'(in_ready), 0);
    @(posedge clk); #1;
    chk("ready_after_release", int'(in_ready), 1);

    for (int i = 0; i < 7; i++) begin
      accept(vecs[i].sc);
      wait_done(lat);
      check_res($sformatf("vec%0d", i), vecs[i]);
      release_out();
    end

    // back-pressure with in_valid toggling fresh data
    accept(vecs[0].sc);
    wait_done(lat);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      scores = 16'($urandom);
      @(posedge clk); #1;
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_ready", int'(in_ready), 0);
      check_res("bp", vecs[0]);
    end
    in_valid = 1'b0;
    release_out();
    @(posedge clk); #1;
    chk("idle_no_capture", int'(in_ready), 1);
    accept(vecs[3].sc);
    wait_done(lat);
    check_res("after_bp", vecs[3]);
    release_out();

    // reset while SCAN holds cnt=2
    accept(mk(9, 1, 2, 3));
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", int'(in_ready), 0);
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_class", int'(cls), 0);
    chk("mid_rst_max", int'(mx), 0);
    chk("mid_rst_tie", int'(tie), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_hold_valid", int'(out_valid), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", int'(in_ready), 1);
    chk("post_rst_valid", int'(out_valid), 0);
    accept(mk(1, 0, 0, 0));
    wait_done(lat);
    check_res("post_rst", '{mk(1, 0, 0, 0), 2'd0, 4'd1, 1'b0});
    release_out();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
